// File: rtl/empaquetador_bytes.sv
// empaquetador_bytes: packs four accepted 2-bit words into one byte.
// Completed bytes are queued in a small FIFO that feeds a byte-wide
// valid/ready consumer. A word offered while ready_out is low is dropped
// and sets a sticky overflow flag.
module empaquetador_bytes #(
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset_L,     // active-high asynchronous reset
  input  logic [1:0] data_in,
  input  logic       valid_in,
  input  logic       flush,
  output logic       ready_out,
  output logic [7:0] data_out,
  output logic       valid_out,
  input  logic       ready_in,
  output logic [1:0] word_count,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [7:0]    shreg;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_count;

  logic          accept;
  logic          push;
  logic          pop;
  logic [2:0]    shamt;
  logic [7:0]    slot_bits;
  logic [7:0]    packed_byte;

  // Position the incoming word in its slot and merge it with the held words
  always_comb begin
    shamt = 3'd0;
    if (MSB_FIRST) shamt = 3'd6 - {word_count, 1'b0};
    else           shamt = {word_count, 1'b0};
    slot_bits   = {6'b000000, data_in} << shamt;
    packed_byte = shreg | slot_bits;
  end

  // Handshake decode; ready_out depends on registered state only, so a pop
  // in the same cycle never raises it
  always_comb begin
    ready_out = !((word_count == 2'd3) && (fifo_count == FULL));
    valid_out = (fifo_count != '0);
    data_out  = valid_out ? mem[rd_ptr] : 8'h00;
    accept    = valid_in & ready_out;
    push      = accept & ~flush & (word_count == 2'd3);
    pop       = valid_out & ready_in;
  end

  // Partial-group assembly; flush wins over a word accepted on the same edge
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      shreg      <= 8'h00;
      word_count <= 2'd0;
    end else if (flush) begin
      shreg      <= 8'h00;
      word_count <= 2'd0;
    end else if (accept) begin
      if (word_count == 2'd3) begin
        shreg      <= 8'h00;
        word_count <= 2'd0;
      end else begin
        shreg      <= packed_byte;
        word_count <= word_count + 2'd1;
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents behind an empty FIFO are never visible
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= packed_byte;
  end

  // Sticky overflow: a valid word arrived while the block could not take it
  always_ff @(posedge clk or posedge reset_L) begin
    if (reset_L)                    overflow <= 1'b0;
    else if (valid_in && !ready_out) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_empaquetador_bytes.sv
// Directed bench for empaquetador_bytes: MSB-first instance checked in
// detail, LSB-first instance sharing the same stimulus checked for order.
module tb_empaquetador_bytes;

  logic       clk;
  logic       reset_L;
  logic [1:0] data_in;
  logic       valid_in;
  logic       flush;
  logic       ready_in;

  logic       ready_out, valid_out, overflow;
  logic [7:0] data_out;
  logic [1:0] word_count;

  logic       l_ready_out, l_valid_out, l_overflow;
  logic [7:0] l_data_out;
  logic [1:0] l_word_count;

  int errors = 0;
  int checks = 0;

  empaquetador_bytes #(.DEPTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .flush(flush), .ready_out(ready_out), .data_out(data_out),
    .valid_out(valid_out), .ready_in(ready_in), .word_count(word_count),
    .overflow(overflow)
  );

  empaquetador_bytes #(.DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
    .flush(flush), .ready_out(l_ready_out), .data_out(l_data_out),
    .valid_out(l_valid_out), .ready_in(ready_in), .word_count(l_word_count),
    .overflow(l_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [1:0] w);
    data_in  = w;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  function automatic logic [7:0] pack_msb(input logic [1:0] w [4]);
    return {w[0], w[1], w[2], w[3]};
  endfunction

  function automatic logic [7:0] pack_lsb(input logic [1:0] w [4]);
    return {w[3], w[2], w[1], w[0]};
  endfunction

  logic [7:0] exp_full [4] = '{8'h1B, 8'h6C, 8'hB1, 8'hC6};

  initial begin
    logic [7:0]  q_msb [$];
    logic [7:0]  q_lsb [$];
    logic [1:0]  grp [4];
    int          gcnt;
    int          sent;
    int          budget;
    logic        v;
    logic [7:0]  em, el;

    reset_L = 1'b1; data_in = 2'b00; valid_in = 1'b0; flush = 1'b0; ready_in = 1'b0;
    #1;
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_ready_out", ready_out, 1'b1);
    chk("rst_word_count", word_count, 2'd0);
    chk("rst_overflow", overflow, 1'b0);
    #2 reset_L = 1'b0;
    tick();

    // Packing order, 1-cycle latency from 4th accept
    ready_in = 1'b1;
    word(2'b11);
    chk("pk_wc1", word_count, 2'd1);
    word(2'b00);
    word(2'b10);
    chk("pk_wc3", word_count, 2'd3);
    chk("pk_valid_before", valid_out, 1'b0);
    word(2'b01);
    chk("pk_valid_after", valid_out, 1'b1);
    chk("pk_msb_byte", data_out, 8'hC9);
    chk("pk_lsb_byte", l_data_out, 8'h63);
    chk("pk_wc0", word_count, 2'd0);
    tick();
    chk("pk_popped", valid_out, 1'b0);

    // Fill the FIFO under back-pressure
    ready_in = 1'b0;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++) word(2'((j + k) & 3));
    chk("full_count", dut.fifo_count, 3'd4);
    chk("full_valid", valid_out, 1'b1);
    chk("full_ready_wc0", ready_out, 1'b1);
    word(2'b01); word(2'b01); word(2'b01);
    chk("full_wc3", word_count, 2'd3);
    chk("full_ready_low", ready_out, 1'b0);
    chk("full_ovf_before", overflow, 1'b0);
    word(2'b10);
    chk("full_ovf_set", overflow, 1'b1);
    chk("full_dropped_wc", word_count, 2'd3);
    chk("full_count_kept", dut.fifo_count, 3'd4);
    ready_in = 1'b1;
    chk("drain_ready_same_cycle", ready_out, 1'b0);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("drain_byte%0d", j), data_out, exp_full[j]);
      tick();
      if (j == 0) chk("drain_ready_back", ready_out, 1'b1);
    end
    chk("drain_empty", valid_out, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush3_wc", word_count, 2'd0);
    chk("ovf_sticky_flush", overflow, 1'b1);

    // Simultaneous push and pop with two bytes held
    ready_in = 1'b0;
    word(2'b10); word(2'b10); word(2'b01); word(2'b01);
    word(2'b00); word(2'b11); word(2'b11); word(2'b00);
    word(2'b10); word(2'b01); word(2'b01);
    chk("pp_count_before", dut.fifo_count, 3'd2);
    ready_in = 1'b1;
    chk("pp_head_before", data_out, 8'hA5);
    word(2'b10);
    chk("pp_count_after", dut.fifo_count, 3'd2);
    chk("pp_head1", data_out, 8'h3C);
    tick();
    chk("pp_head2", data_out, 8'h96);
    tick();
    chk("pp_empty", valid_out, 1'b0);

    // Flush with a word offered on the same edge
    word(2'b11); word(2'b11);
    chk("fl_wc2", word_count, 2'd2);
    flush = 1'b1;
    word(2'b11);
    flush = 1'b0;
    chk("fl_wc0", word_count, 2'd0);
    chk("fl_no_byte", valid_out, 1'b0);
    word(2'b00); word(2'b01); word(2'b10); word(2'b11);
    chk("fl_clean_byte", data_out, 8'h1B);
    chk("fl_clean_lsb", l_data_out, 8'hE4);
    tick();
    chk("fl_popped", valid_out, 1'b0);

    // Asynchronous reset mid-group with one byte stored
    ready_in = 1'b0;
    word(2'b01); word(2'b10); word(2'b11); word(2'b00);
    word(2'b11); word(2'b10);
    chk("ar_wc2", word_count, 2'd2);
    chk("ar_valid", valid_out, 1'b1);
    #2 reset_L = 1'b1;
    #1;
    chk("ar_data_out", data_out, 8'h00);
    chk("ar_valid_out", valid_out, 1'b0);
    chk("ar_ready_out", ready_out, 1'b1);
    chk("ar_word_count", word_count, 2'd0);
    chk("ar_overflow", overflow, 1'b0);
    #1 reset_L = 1'b0;
    tick();
    ready_in = 1'b1;
    word(2'b01); word(2'b11); word(2'b00); word(2'b10);
    chk("ar_new_byte", data_out, 8'h72);
    chk("ar_new_lsb", l_data_out, 8'h8D);
    tick();
    chk("ar_popped", valid_out, 1'b0);

    // Random streaming of 40 bytes across pointer wrap
    gcnt = 0; sent = 0; budget = 0;
    while ((sent < 160 || q_msb.size() != 0) && budget < 3000) begin
      budget++;
      ready_in = (sent < 160) ? 1'($urandom_range(0, 1)) : 1'b1;
      v        = (sent < 160) && ($urandom_range(0, 3) != 0) && ready_out;
      data_in  = 2'($urandom_range(0, 3));
      valid_in = v;
      if (valid_out && ready_in) begin
        if (q_msb.size() == 0) begin
          chk("st_unexpected_pop", valid_out, 1'b0);
        end else begin
          em = q_msb.pop_front();
          el = q_lsb.pop_front();
          chk("st_msb_byte", data_out, em);
          chk("st_lsb_byte", l_data_out, el);
        end
      end
      if (v) begin
        grp[gcnt] = data_in;
        gcnt++;
        sent++;
        if (gcnt == 4) begin
          q_msb.push_back(pack_msb(grp));
          q_lsb.push_back(pack_lsb(grp));
          gcnt = 0;
        end
      end
      tick();
      valid_in = 1'b0;
    end
    chk("st_all_sent", sent, 160);
    chk("st_queue_empty", q_msb.size(), 0);
    chk("st_valid_end", valid_out, 1'b0);
    chk("st_no_overflow", overflow, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/empaquetador_bytes.md
Name: empaquetador_bytes

Overview:
- Downstream stage of the 2-bit registered multiplexor stage: consumes its 2-bit output words and packs four consecutive accepted words into one byte.
- Completed bytes are buffered in a small synchronous FIFO and presented on a valid/ready interface to the next byte-wide consumer.
- Upstream back-pressure is reported through ready_out; a word offered while ready_out is low is dropped and flagged.

Parameters:
- DEPTH, 4: number of byte entries in the output FIFO. Power of two, minimum 2.
- MSB_FIRST, 1: packing order. With 1, the first word of a group lands in bits [7:6]. With 0, it lands in bits [1:0].

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_L  input  1  asynchronous reset, active-high. Asserted at 1, it clears all state immediately, independent of clk.
- data_in  input  2  word from the upstream mux stage.
- valid_in  input  1  data_in is valid this cycle.
- flush  input  1  synchronous; discards the partially assembled group.
- ready_out  output  1  block can accept a word this cycle.
- data_out  output  8  byte at the FIFO head.
- valid_out  output  1  data_out is valid (FIFO not empty).
- ready_in  input  1  downstream accepts data_out this cycle.
- word_count  output  2  number of words currently held in the partial group (0..3).
- overflow  output  1  sticky error flag.

Behaviour:
- Reset values while reset_L is 1: data_out=8'h00, valid_out=0, ready_out=1, word_count=0, overflow=0. The FIFO is empty, its pointers are 0, and the shift register is 8'h00. Reset asserted mid-operation discards the partial group and all FIFO contents.
- Accept condition: accept = valid_in & ready_out. On an accept, data_in is written into slot word_count of the shift register and word_count increments.
  - MSB_FIRST=1: slot k occupies bits [7-2k:6-2k].
  - MSB_FIRST=0: slot k occupies bits [2k+1:2k].
- Group completion: when an accept occurs with word_count==3, the assembled byte (the three held words plus the current data_in) is pushed into the FIFO on the same edge, word_count wraps to 0, and the shift register clears to 8'h00.
- ready_out is combinational from state only: ready_out = !(word_count==3 && fifo_count==DEPTH).
  - There is no combinational path from ready_in to ready_out.
  - A pop in the same cycle does not raise ready_out.
- Pop condition: pop = valid_out & ready_in. valid_out = (fifo_count != 0). data_out is always the FIFO head; it is 8'h00 when the FIFO is empty.
- Simultaneous push and pop: both take effect and fifo_count is unchanged. On an empty FIFO a push makes the byte visible the following cycle; there is no bypass.
- Latency: from the edge that accepts the 4th word to valid_out=1 is 1 cycle, when the FIFO was empty.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH; full means fifo_count==DEPTH, empty means fifo_count==0.
- flush: on an edge with flush=1, word_count is set to 0 and the shift register is cleared. Any word accepted on that edge is discarded. FIFO contents and pops are unaffected.
- overflow: set on any edge where valid_in=1 and ready_out=0; the offered word is dropped. It stays at 1 until reset_L is asserted. flush does not clear it.
- Upstream interaction: the mux stage's output changes every clock, so valid_in qualifies each word. The block never samples data_in without valid_in.

Test Plan:
- Reset: assert reset_L=1 mid-group (word_count=2, FIFO holding 1 byte) -> all outputs go to their reset values immediately, without waiting for a clock edge. After release, a new 4-word group packs correctly.
- Packing order: MSB_FIRST=1, ready_in=1, words 2'b11, 2'b00, 2'b10, 2'b01 on consecutive cycles -> data_out=8'hC9 with valid_out high exactly 1 cycle after the 4th accept. MSB_FIRST=0 with the same stimulus -> 8'h63.
- Full and back-pressure: ready_in=0, DEPTH=4, feed 16 words -> 4 bytes stored. Feed 3 more words -> word_count=3 and ready_out=0. One more word offered -> overflow=1 and the word is dropped. Then ready_in=1 -> bytes drain in order, and ready_out returns to 1 the cycle after the first pop.
- Simultaneous push and pop: FIFO holding 2 bytes, 4th word accepted in the same cycle as a pop -> fifo_count stays 2 and the order is preserved.
- Flush: after 2 words (word_count=2), flush=1 together with valid_in=1 -> word_count=0 and no byte is produced. The next 4 words form a clean byte.
- Wrap-around: stream 40 bytes with ready_in toggled pseudo-randomly -> output byte sequence equals the reference model, with no loss and no duplication across pointer wrap.
